echo_path_model_fx: RTL and testbench

//  Parametrised fixed-point echo-path model; successor to the 4-tap double-precision lag generator.
//  Per accepted sample x[n] it produces lag_out = sat(round(sum_k c_k * x[n-k*TAP_SPACING])), k=0..NUM_TAPS-1,

---
 rtl/echo_fx_pkg.sv | 27 ++
 rtl/echo_delay_ram.sv | 33 +++
 rtl/echo_path_model_fx.sv | 133 +++++++++++++
 tb/tb_echo_path_model_fx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/echo_fx_pkg.sv
// Shared fixed-point definitions for the echo path: FSM encoding, Q-format
// defaults and the round/saturate step used by the canceller and converters.
package echo_fx_pkg;

   localparam int Q_DATA_W    = 16;
   localparam int Q_COEF_W    = 16;
   localparam int Q_COEF_FRAC = 14;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_RND  = 2'd2
   } fsm_t;

   // Round half up at bit frac, then clamp to a signed dw-bit range.
   function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] acc,
                                                  input int frac, input int dw);
      logic signed [63:0] r, hi, lo;
      r  = (frac > 0) ? ((acc + (64'sd1 <<< (frac - 1))) >>> frac) : acc;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Circular sample buffer: one write port, one combinational read port,
// synchronous flush. A write in the flush cycle lands after the flush.
module echo_delay_ram #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int AW     = 2
) (
   input  logic              clk_operation,
   input  logic              rst,
   input  logic              clear,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we && waddr == AW'(i)) mem[i] <= wdata;
            else if (clear)            mem[i] <= '0;
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/echo_path_model_fx.sv
// Fixed-point echo-path model: one multiplier time-shared over NUM_TAPS taps,
// shadow/active coefficient banks, rounding and saturation to DATA_W.
module echo_path_model_fx
   import echo_fx_pkg::*;
#(
   parameter int DATA_W      = Q_DATA_W,
   parameter int COEF_W      = Q_COEF_W,
   parameter int COEF_FRAC   = Q_COEF_FRAC,
   parameter int NUM_TAPS    = 4,
   parameter int TAP_SPACING = 1,
   localparam int CA_W       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic              clk_operation,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              bypass,
   input  logic              clear,
   input  logic              coef_we,
   input  logic [CA_W-1:0]   coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] lag_out,
   output logic [DATA_W-1:0] align_out,
   output logic              overrun,
   output logic [7:0]        overrun_cnt
);

   localparam int DEPTH = (NUM_TAPS - 1) * TAP_SPACING + 1;
   localparam int ACC_W = DATA_W + COEF_W + $clog2(NUM_TAPS) + 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW    = DATA_W + COEF_W;

   fsm_t                          state;
   logic [CA_W-1:0]               tap;
   logic [AW-1:0]                 wr_ptr, base, raddr, waddr;
   logic [NUM_TAPS-1:0][COEF_W-1:0] shadow, active;
   logic signed [ACC_W-1:0]       acc;
   logic signed [PW-1:0]          prod;
   logic [DATA_W-1:0]             rdata, x_hold, rnd_val;
   logic                          accept;
   int                            off, rd_i;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign busy    = (state != S_IDLE);
   assign accept  = sample_valid && (state == S_IDLE);
   assign overrun = sample_valid && busy;
   assign waddr   = clear ? '0 : wr_ptr;

   // Tap k looks back k*TAP_SPACING entries from the sample taken at accept.
   always_comb begin
      off  = int'(tap) * TAP_SPACING;
      rd_i = int'(base) - off;
      if (rd_i < 0) rd_i = rd_i + DEPTH;
      raddr = AW'(rd_i);
   end

   assign prod    = PW'($signed(active[tap])) * PW'($signed(rdata));
   assign rnd_val = DATA_W'(rnd_sat(64'(acc), COEF_FRAC, DATA_W));

   echo_delay_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
      .clk_operation(clk_operation),
      .rst          (rst),
      .clear        (clear),
      .we           (accept),
      .waddr        (waddr),
      .wdata        (sample_in),
      .raddr        (raddr),
      .rdata        (rdata)
   );

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         tap         <= '0;
         wr_ptr      <= '0;
         base        <= '0;
         shadow      <= '0;
         active      <= '0;
         acc         <= '0;
         x_hold      <= '0;
         out_valid   <= 1'b0;
         lag_out     <= '0;
         align_out   <= '0;
         overrun_cnt <= '0;
      end else begin
         out_valid <= 1'b0;
         if (coef_we && int'(coef_addr) < NUM_TAPS) shadow[coef_addr] <= coef_data;
         if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
         if (clear) wr_ptr <= '0;
         case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  active <= shadow;
                  wr_ptr <= ptr_inc(waddr);
                  if (bypass) begin
                     out_valid <= 1'b1;
                     lag_out   <= '0;
                     align_out <= sample_in;
                  end else begin
                     state  <= S_MAC;
                     tap    <= '0;
                     acc    <= '0;
                     base   <= waddr;
                     x_hold <= sample_in;
                  end
               end
            end
            S_MAC: begin
               if (clear) begin
                  state <= S_IDLE;
               end else begin
                  acc <= acc + ACC_W'(prod);
                  if (tap == CA_W'(NUM_TAPS - 1)) state <= S_RND;
                  else                            tap   <= tap + CA_W'(1);
               end
            end
            S_RND: begin
               state     <= S_IDLE;
               out_valid <= 1'b1;
               lag_out   <= rnd_val;
               align_out <= x_hold;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_path_model_fx.sv
// Scoreboard bench: the stimulus side runs a sample-history model and queues
// expected outputs; a negedge monitor pops and compares on out_valid.
module tb_echo_path_model_fx;

   localparam int DATA_W      = 16;
   localparam int COEF_W      = 16;
   localparam int COEF_FRAC   = 14;
   localparam int NUM_TAPS    = 4;
   localparam int TAP_SPACING = 1;
   localparam int DEPTH       = (NUM_TAPS - 1) * TAP_SPACING + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              bypass = 1'b0;
   logic              clear = 1'b0;
   logic              coef_we = 1'b0;
   logic [1:0]        coef_addr = '0;
   logic [COEF_W-1:0] coef_data = '0;
   logic              busy, out_valid, overrun;
   logic [DATA_W-1:0] lag_out, align_out;
   logic [7:0]        overrun_cnt;

   echo_path_model_fx #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC),
      .NUM_TAPS(NUM_TAPS), .TAP_SPACING(TAP_SPACING)
   ) dut (
      .clk_operation(clk), .rst(rst_n), .sample_valid(sample_valid),
      .sample_in(sample_in), .bypass(bypass), .clear(clear), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
      .out_valid(out_valid), .lag_out(lag_out), .align_out(align_out),
      .overrun(overrun), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; int lag; int align; } exp_t;
   exp_t sb[$];

   int hist[$];               // most recent sample first
   int shadow_m[NUM_TAPS];
   int active_m[NUM_TAPS];
   int busy_left = 0;
   int ovr_cnt_m = 0;
   int exp_cnt = 0;
   bit exp_busy = 0, exp_ovr = 0;
   int errors = 0, checks = 0;

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
   endtask

   function automatic int model_lag();
      longint s, n, d, q;
      s = 0;
      for (int k = 0; k < NUM_TAPS; k++)
         if (k * TAP_SPACING < hist.size())
            s += longint'(active_m[k]) * longint'(hist[k * TAP_SPACING]);
      d = longint'(1) << COEF_FRAC;
      n = s + d / 2;
      q = (n >= 0) ? n / d : -((-n + d - 1) / d);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic int to_s16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   task automatic step(input bit sv, input int x, input bit byp, input bit clr,
                       input bit cwe, input int ca, input int cd);
      int sx;
      bit acc_ok;
      @(posedge clk); #1;
      sample_valid = sv; sample_in = x[15:0]; bypass = byp; clear = clr;
      coef_we = cwe; coef_addr = ca[1:0]; coef_data = cd[15:0];
      sx       = to_s16(x);
      exp_busy = (busy_left > 0);
      exp_ovr  = sv && exp_busy;
      exp_cnt  = ovr_cnt_m;
      if (exp_ovr && ovr_cnt_m < 255) ovr_cnt_m++;
      acc_ok = sv && !exp_busy;
      if (clr && busy_left >= 2) begin
         busy_left = 0;
         void'(sb.pop_back());
      end else if (busy_left > 0) busy_left--;
      if (clr) hist.delete();
      if (acc_ok) begin
         for (int k = 0; k < NUM_TAPS; k++) active_m[k] = shadow_m[k];
         hist.push_front(sx);
         if (hist.size() > DEPTH) void'(hist.pop_back());
         if (byp) sb.push_back('{cyc + 1, 0, sx});
         else begin
            sb.push_back('{cyc + NUM_TAPS + 2, model_lag(), sx});
            busy_left = NUM_TAPS + 1;
         end
      end
      if (cwe && ca < NUM_TAPS) shadow_m[ca] = to_s16(cd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic send(input int x);
      step(1, x, 0, 0, 0, 0, 0);
      idle(NUM_TAPS + 1);
   endtask

   task automatic setc(input int c0, input int c1, input int c2, input int c3);
      step(0, 0, 0, 0, 1, 0, c0);
      step(0, 0, 0, 0, 1, 1, c1);
      step(0, 0, 0, 0, 1, 2, c2);
      step(0, 0, 0, 0, 1, 3, c3);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      sample_valid = 0; bypass = 0; clear = 0; coef_we = 0;
      sb.delete(); hist.delete();
      for (int k = 0; k < NUM_TAPS; k++) begin shadow_m[k] = 0; active_m[k] = 0; end
      busy_left = 0; ovr_cnt_m = 0; exp_cnt = 0; exp_busy = 0; exp_ovr = 0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_lag_out", lag_out, 0);
      check("rst_align_out", align_out, 0);
      check("rst_overrun", overrun, 0);
      check("rst_overrun_cnt", overrun_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            if (sb.size() == 0) check("spurious_out_valid", 1, 0);
            else begin
               e = sb.pop_front();
               check("out_valid_cycle", cyc, e.due);
               check("lag_out", $signed(lag_out), e.lag);
               check("align_out", $signed(align_out), e.align);
            end
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_out_valid", 0, 1);
            void'(sb.pop_front());
         end
         check("busy", busy, exp_busy);
         check("overrun", overrun, exp_ovr);
         check("overrun_cnt", overrun_cnt, exp_cnt);
      end
   end

   initial begin
      do_reset();
      // impulse response through the four taps
      setc('h4000, 'h2000, 'h1000, 'h0800);
      send(1000); send(0); send(0); send(0); send(0);
      // saturation both directions
      setc('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF);
      repeat (4) send(32767);
      repeat (4) send(-32768);
      // rounding at the half-LSB boundary
      setc(1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      send(8192); send(-8192);
      // two back-to-back samples after a fresh reset
      do_reset();
      setc('h4000, 0, 0, 0);
      step(1, 100, 0, 0, 0, 0, 0);
      step(1, 200, 0, 0, 0, 0, 0);
      idle(8);
      check("overrun_cnt_pair", overrun_cnt, 1);
      // shadow write during MAC applies to the following sample only
      step(1, 3000, 0, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 1, 0, 'h2000);
      idle(3);
      send(3000);
      // bypass, including back-to-back accepts
      step(1, 1234, 1, 0, 0, 0, 0);
      idle(2);
      step(1, -5, 1, 0, 0, 0, 0);
      step(1, 77, 1, 0, 0, 0, 0);
      idle(2);
      // clear mid-MAC, then impulse on empty history
      setc('h4000, 'h2000, 'h1000, 'h0800);
      step(1, 500, 0, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 1, 0, 0, 0);
      idle(4);
      send(1000); send(0); send(0); send(0);
      // reset mid-MAC: coefficients and history back to zero
      step(1, 700, 0, 0, 0, 0, 0);
      idle(2);
      do_reset();
      send(1000);
      setc('h4000, 'h2000, 'h1000, 'h0800);
      send(1000); send(0); send(0); send(0);
      // continuous requests drive the drop counter into saturation
      for (int i = 0; i < 400; i++) step(1, to_s16(int'($urandom)), 0, 0, 0, 0, 0);
      idle(8);
      check("overrun_cnt_sat", overrun_cnt, 255);
      // randomized mix
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 2) == 0, to_s16(int'($urandom)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)),
              to_s16(int'($urandom)));
      idle(20);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
